// File: rtl/inst_fetch_pkg.sv
// Shared fetch-stage types: core widths, request FSM states and the {inst, pc}
// layout used for prefetch-queue entries.
package inst_fetch_pkg;

  localparam int CORE_ADDR_W = 32;
  localparam int INST_W      = 32;

  typedef enum logic {
    S_IDLE,
    S_REQ
  } req_state_e;

  typedef struct packed {
    logic [INST_W-1:0]      inst;
    logic [CORE_ADDR_W-1:0] pc;
  } fetch_entry_t;

  localparam int ENTRY_W = $bits(fetch_entry_t);

endpackage

// File: rtl/fetch_queue.sv
// Synchronous circular FIFO with push, pop, clear and occupancy count.
// The head entry is read combinationally so a pop shows the next entry without a bubble.
module fetch_queue #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic [CNT_W-1:0] count,
  output logic             empty,
  output logic             full
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  assign empty     = (count_q == '0);
  assign full      = (count_q == CNT_W'(DEPTH));
  assign count     = count_q;
  assign head_data = mem_q[rd_ptr_q];

  always_comb begin
    do_pop   = pop && !empty;
    do_push  = push && (!full || do_pop);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clr) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      wr_ptr_d = wr_ptr_q + PTR_W'(do_push);
      rd_ptr_d = rd_ptr_q + PTR_W'(do_pop);
      count_d  = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      assert (clr || !(push && full && !pop));
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !clr) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch: credit-limited PC intake, one pending memory request, in-order
// prefetch queue, flush by counting in-flight responses to discard.
// States: IDLE | no request pending;  REQ | mem_req/mem_addr held until mem_gnt
module inst_fetch
  import inst_fetch_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = CORE_ADDR_W
) (
  input  logic              CCLK,
  input  logic              CRST,
  input  logic              pc_valid,
  input  logic [ADDR_W-1:0] pc,
  output logic              pc_ready,
  input  logic              flush,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [INST_W-1:0] mem_rdata,
  output logic              inst_valid,
  output logic [INST_W-1:0] inst,
  output logic [ADDR_W-1:0] inst_pc,
  input  logic              inst_ready,
  output logic              inst_mem_wait
);

  localparam int QCNT_W = $clog2(DEPTH) + 1;
  localparam int CNT_W  = $clog2(DEPTH) + 2;
  localparam int ENT_W  = INST_W + ADDR_W;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  req_state_e        state_q, state_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [CNT_W-1:0]  outstanding_q, outstanding_d;
  logic [CNT_W-1:0]  discard_q, discard_d;
  logic              drop_q, drop_d;

  logic              gnt_fire, accept, rsp_keep;
  logic [CNT_W-1:0]  used;
  logic              tag_push, tag_pop, tag_empty;
  logic [ADDR_W-1:0] tag_head;
  logic              q_push, q_pop, q_empty;
  logic [ENT_W-1:0]  q_head;
  logic [QCNT_W-1:0] q_count;
  logic [QCNT_W-1:0] unused_tag_count;
  logic              unused_tag_full, unused_q_full;

  assign mem_req  = (state_q == S_REQ);
  assign mem_addr = mem_addr_q;
  assign gnt_fire = mem_req && mem_gnt;
  assign used     = CNT_W'(q_count) + outstanding_q + CNT_W'(mem_req);
  assign pc_ready = (!mem_req || mem_gnt) && !flush && !CRST && (used < DEPTH_C);
  assign accept   = pc_valid && pc_ready;
  assign rsp_keep = mem_rvalid && (discard_q == '0);

  always_comb begin
    state_d       = state_q;
    mem_addr_d    = mem_addr_q;
    pc_d          = pc_q;
    drop_d        = drop_q;
    outstanding_d = outstanding_q + CNT_W'(gnt_fire) - CNT_W'(mem_rvalid);
    discard_d     = discard_q - CNT_W'(mem_rvalid && (discard_q != '0));
    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d    = S_REQ;
          mem_addr_d = {pc[ADDR_W-1:2], 2'b00};
          pc_d       = pc;
        end
      end
      S_REQ: begin
        if (gnt_fire) begin
          drop_d = 1'b0;
          if (accept) begin
            mem_addr_d = {pc[ADDR_W-1:2], 2'b00};
            pc_d       = pc;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    // A request still waiting for grant at flush is owed one discarded response.
    if (flush) begin
      discard_d = outstanding_d + CNT_W'(mem_req && !mem_gnt);
      drop_d    = mem_req && !mem_gnt;
    end
  end

  always_ff @(posedge CCLK) begin
    if (CRST) begin
      state_q       <= S_IDLE;
      mem_addr_q    <= '0;
      pc_q          <= '0;
      outstanding_q <= '0;
      discard_q     <= '0;
      drop_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      mem_addr_q    <= mem_addr_d;
      pc_q          <= pc_d;
      outstanding_q <= outstanding_d;
      discard_q     <= discard_d;
      drop_q        <= drop_d;
    end
  end

  assign tag_push = gnt_fire && !drop_q;
  assign tag_pop  = rsp_keep && !tag_empty;
  assign q_push   = rsp_keep && !flush;
  assign q_pop    = inst_valid && inst_ready;

  fetch_queue #(.DEPTH(DEPTH), .WIDTH(ADDR_W)) u_tag_fifo (
    .clk       (CCLK),
    .rst       (CRST),
    .clr       (flush),
    .push      (tag_push),
    .push_data (pc_q),
    .pop       (tag_pop),
    .head_data (tag_head),
    .count     (unused_tag_count),
    .empty     (tag_empty),
    .full      (unused_tag_full)
  );

  fetch_queue #(.DEPTH(DEPTH), .WIDTH(ENT_W)) u_inst_queue (
    .clk       (CCLK),
    .rst       (CRST),
    .clr       (flush),
    .push      (q_push),
    .push_data ({mem_rdata, tag_head}),
    .pop       (q_pop),
    .head_data (q_head),
    .count     (q_count),
    .empty     (q_empty),
    .full      (unused_q_full)
  );

  assign inst_valid    = !q_empty;
  assign inst          = inst_valid ? q_head[ENT_W-1 -: INST_W] : '0;
  assign inst_pc       = inst_valid ? q_head[ADDR_W-1:0] : '0;
  assign inst_mem_wait = !inst_valid && ((outstanding_q > discard_q) || mem_req);

endmodule

// File: tb/tb_inst_fetch.sv
// Randomised and directed checks of inst_fetch against an in-order expectation queue
// and a behavioural in-order memory with random grant and latency.
module tb_inst_fetch;

  logic        CCLK = 1'b0;
  logic        CRST;
  logic        pc_valid;
  logic [31:0] pc;
  logic        pc_ready;
  logic        flush;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_ready;
  logic        inst_mem_wait;

  inst_fetch #(.DEPTH(4), .ADDR_W(32)) dut (
    .CCLK          (CCLK),
    .CRST          (CRST),
    .pc_valid      (pc_valid),
    .pc            (pc),
    .pc_ready      (pc_ready),
    .flush         (flush),
    .mem_req       (mem_req),
    .mem_addr      (mem_addr),
    .mem_gnt       (mem_gnt),
    .mem_rvalid    (mem_rvalid),
    .mem_rdata     (mem_rdata),
    .inst_valid    (inst_valid),
    .inst          (inst),
    .inst_pc       (inst_pc),
    .inst_ready    (inst_ready),
    .inst_mem_wait (inst_mem_wait)
  );

  always #5 CCLK = ~CCLK;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } mrsp_t;

  mrsp_t       mq[$];
  logic [31:0] exp_q[$];
  int          pop_cyc[$];
  int          n_cmp = 0;
  int          n_mis = 0;
  int          cyc = 0;
  int          n_resp = 0;
  int          gnt_pct = 100;
  int          lat_min = 1;
  int          lat_max = 1;
  logic        last_acc = 1'b0;
  logic        prev_acc = 1'b0;
  logic [31:0] prev_pc = '0;
  logic        prev_stall = 1'b0;
  logic [31:0] prev_mem_addr = '0;
  logic        prev_flush = 1'b0;
  logic        prev_rst = 1'b0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a == 32'h100) ? 32'hDEADBEEF : {2'b00, a[31:2]};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // One clock cycle: memory drives its side, outputs are checked, the model advances.
  task automatic tick();
    logic acc, pop, gnt;
    logic [31:0] e;
    mem_gnt = !CRST && ($urandom_range(99) < gnt_pct);
    if (!CRST && mq.size() > 0 && mq[0].due <= cyc) begin
      mem_rvalid = 1'b1;
      mem_rdata  = mem_word(mq[0].addr);
      void'(mq.pop_front());
      n_resp++;
    end else begin
      mem_rvalid = 1'b0;
      mem_rdata  = $urandom;
    end
    #1;
    if (prev_acc) begin
      chk("acc_req", mem_req, 1);
      chk("acc_addr", mem_addr, {prev_pc[31:2], 2'b00});
    end
    if (prev_stall) begin
      chk("stall_req", mem_req, 1);
      chk("stall_addr", mem_addr, prev_mem_addr);
    end
    if (prev_flush) chk("flush_inv", inst_valid, 0);
    if (flush)      chk("flush_rdy", pc_ready, 0);
    if (CRST)       chk("rst_rdy", pc_ready, 0);
    if (prev_rst) begin
      chk("rst_req", mem_req, 0);
      chk("rst_addr", mem_addr, 0);
      chk("rst_iv", inst_valid, 0);
      chk("rst_inst", inst, 0);
      chk("rst_ipc", inst_pc, 0);
      chk("rst_wait", inst_mem_wait, 0);
    end
    pop = inst_valid && inst_ready && !CRST;
    if (pop) begin
      chk("pop_pending", exp_q.size() > 0, 1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("inst_pc", inst_pc, e);
        chk("inst_data", inst, mem_word({e[31:2], 2'b00}));
      end
      pop_cyc.push_back(cyc);
    end
    acc = pc_valid && pc_ready && !CRST;
    if (acc) exp_q.push_back(pc);
    if (flush) exp_q.delete();
    gnt = mem_req && mem_gnt && !CRST;
    if (gnt) mq.push_back('{addr: mem_addr, due: cyc + $urandom_range(lat_max, lat_min)});
    if (CRST) begin
      exp_q.delete();
      mq.delete();
    end
    last_acc      = acc;
    prev_acc      = acc;
    prev_pc       = pc;
    prev_stall    = mem_req && !mem_gnt && !CRST;
    prev_mem_addr = mem_addr;
    prev_flush    = flush && !CRST;
    prev_rst      = CRST;
    @(posedge CCLK);
    cyc++;
    @(negedge CCLK);
  endtask

  task automatic drain();
    int i;
    pc_valid   = 1'b0;
    flush      = 1'b0;
    inst_ready = 1'b1;
    gnt_pct    = 100;
    for (i = 0; i < 200 && (exp_q.size() > 0 || mq.size() > 0 || mem_req || inst_valid); i++) tick();
    chk("drain_idle", {exp_q.size() == 0, mq.size() == 0, mem_req, inst_valid}, 4'b1100);
  endtask

  initial begin
    int n, r0;
    CRST = 1'b1; pc_valid = 1'b0; pc = '0; flush = 1'b0;
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0; inst_ready = 1'b0;
    @(negedge CCLK);
    repeat (3) tick();
    CRST = 1'b0;
    tick();

    // single fetch
    gnt_pct = 100; lat_min = 1; lat_max = 1;
    pc_valid = 1'b1; pc = 32'h100;
    for (int i = 0; i < 10 && !last_acc; i++) tick();
    chk("single_acc", last_acc, 1);
    pc_valid = 1'b0;
    for (int i = 0; i < 10 && !inst_valid; i++) tick();
    chk("single_inst", inst, 32'hDEADBEEF);
    chk("single_pc", inst_pc, 32'h100);
    drain();

    // streaming, one instruction per cycle
    pop_cyc.delete();
    inst_ready = 1'b1;
    n = 0;
    for (int i = 0; i < 60 && pop_cyc.size() < 16; i++) begin
      pc_valid = (n < 16);
      pc = 32'(n * 4);
      tick();
      if (last_acc) n++;
    end
    chk("stream_n", pop_cyc.size(), 16);
    for (int i = 1; i < pop_cyc.size(); i++) chk("stream_gap", pop_cyc[i] - pop_cyc[i-1], 1);
    drain();

    // backpressure
    inst_ready = 1'b0; n = 0;
    for (int i = 0; i < 15; i++) begin
      pc_valid = 1'b1; pc = 32'h600 + 32'(4 * n);
      tick();
      if (last_acc) n++;
    end
    chk("bp_reqs", n, 4);
    chk("bp_ready", pc_ready, 0);
    pc_valid = 1'b0; inst_ready = 1'b1; pop_cyc.delete();
    for (int i = 0; i < 20 && pop_cyc.size() < 4; i++) tick();
    chk("bp_drain", pop_cyc.size(), 4);
    pc_valid = 1'b1; pc = 32'h700;
    for (int i = 0; i < 10 && !last_acc; i++) tick();
    chk("bp_resume", last_acc, 1);
    drain();

    // flush with two outstanding and one ungranted request
    gnt_pct = 100; lat_min = 8; lat_max = 8; inst_ready = 1'b1; n = 0;
    for (int i = 0; i < 20 && n < 3; i++) begin
      pc_valid = 1'b1; pc = 32'h300 + 32'(4 * n);
      tick();
      if (last_acc) n++;
    end
    gnt_pct = 0; pc_valid = 1'b0;
    tick();
    chk("fl_pend", mem_req, 1);
    r0 = n_resp;
    flush = 1'b1;
    tick();
    flush = 1'b0; gnt_pct = 100;
    for (int i = 0; i < 12; i++) begin
      tick();
      chk("fl_no_inst", inst_valid, 0);
    end
    chk("fl_resp", n_resp - r0, 3);
    lat_min = 1; lat_max = 1;
    inst_ready = 1'b0;
    pc_valid = 1'b1; pc = 32'h200;
    for (int i = 0; i < 10 && !last_acc; i++) tick();
    pc_valid = 1'b0;
    for (int i = 0; i < 20 && !inst_valid; i++) tick();
    chk("fl_new_pc", inst_pc, 32'h200);
    chk("fl_new_inst", inst, 32'h80);
    drain();

    // grant withheld
    gnt_pct = 0; pc_valid = 1'b1; pc = 32'h400;
    for (int i = 0; i < 10 && !last_acc; i++) tick();
    pc = 32'h404;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("gl_req", mem_req, 1);
      chk("gl_addr", mem_addr, 32'h400);
      chk("gl_wait", inst_mem_wait, 1);
      chk("gl_noacc", last_acc, 0);
    end
    pc_valid = 1'b0;
    drain();

    // reset mid-stream with two queued entries
    inst_ready = 1'b0; n = 0;
    for (int i = 0; i < 10 && n < 2; i++) begin
      pc_valid = 1'b1; pc = 32'h500 + 32'(4 * n);
      tick();
      if (last_acc) n++;
    end
    pc_valid = 1'b0;
    repeat (4) tick();
    chk("rst_q2", dut.q_count, 2);
    CRST = 1'b1;
    tick();
    CRST = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("rst_stale", inst_valid, 0);
    end
    drain();

    // randomised traffic
    lat_min = 1; lat_max = 4;
    for (int i = 0; i < 2500; i++) begin
      gnt_pct    = 70;
      pc_valid   = ($urandom_range(99) < 70);
      pc         = $urandom & 32'hFFFF_FFFC;
      inst_ready = ($urandom_range(99) < 60);
      flush      = ($urandom_range(99) < 3);
      tick();
    end
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
